// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default bit timing for the 6 MHz HFOSC clock.
package uart_pkg;
  localparam int CLK_HZ = 6_000_000;
  localparam int BAUD = 115_200;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronizes rx and deframes one 8N1 byte, pulsing byte_valid or frame_err.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic sync1, rx_s, valid_n, err_n;
  assign byte_data = shreg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      state <= S_IDLE;
      timer <= '0;
      idx <= '0;
      shreg <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1 <= rx;
      rx_s <= sync1;
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      shreg <= shreg_n;
      byte_valid <= valid_n;
      frame_err <= err_n;
    end
  end
  // Timer idles at zero outside the timed states so each timed state starts counting from 0.
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n = idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    err_n = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        state_n = rx_s ? S_IDLE : S_START;
      end
      S_START: if (timer == HALF) begin
        timer_n = '0;
        idx_n = '0;
        state_n = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (timer == FULL) begin
        timer_n = '0;
        shreg_n = {rx_s, shreg[7:1]};
        idx_n = idx + 1'b1;
        state_n = (idx == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (timer == FULL) begin
        timer_n = '0;
        valid_n = rx_s;
        err_n = !rx_s;
        state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        timer_n = '0;
        state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: packs four UART bytes little-endian into a word held in a one-entry valid/ready buffer.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun
);
  logic [7:0] byte_data;
  logic byte_valid, done, take;
  logic [1:0] cnt;
  logic [23:0] assembly;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );
  assign done = byte_valid && cnt == 2'd3;
  assign take = done && (!word_valid || word_ready);
  // Bytes shift in from the top so byte 0 ends up in [7:0] once byte 3 arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      assembly <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done && !take;
      if (frame_err) cnt <= '0;
      else if (byte_valid) begin
        cnt <= cnt + 1'b1;
        assembly <= {byte_data, assembly[23:8]};
      end
      if (take) begin
        word_out <= {byte_data, assembly};
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) word_valid <= 1'b0;
    end
  end
endmodule
